// File: rtl/apb_uart_tx.sv
// apb_uart_tx: APB4 slave with a TX byte FIFO feeding an 8N1 UART serializer.
// Optional build macro UART_TX_PARITY_EN adds an even parity bit (8E1 frame).
//
// state  | meaning
// IDLE   | line high, waiting for enable and a queued byte
// START  | start bit (0) for one bit period
// DATA   | 8 data bits, LSB first, one bit period each
// PARITY | even parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit (1), then next frame back-to-back or IDLE
module apb_uart_tx #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      uart_tx,
    output logic                      tx_empty_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,S_PARITY = 3'd4
`endif
    } state_t;

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr, r_rptr;
    logic [15:0] r_div;
    logic        r_enable;

    state_t      r_state, w_state_nxt;
    logic        r_tx, w_tx_nxt;
    logic [15:0] r_baud_cnt, w_baud_nxt;
    logic [15:0] r_div_lat, w_div_lat_nxt;
    logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_parity, w_parity_nxt;
    logic        w_start, w_pop;

    logic        w_access, w_data_wr, w_div_wr, w_ctrl_wr, w_clear, w_push;
    logic [1:0]  w_addr;
    logic        w_empty, w_full, w_busy, w_baud_tc;
    logic [AW:0] w_level;
    logic [3:0]  w_level_rpt;
    logic [7:0]  w_fifo_rd;
    logic        w_unused;

    assign w_access    = PSEL & PENABLE;
    assign w_addr      = PADDR[3:2];
    assign w_data_wr   = w_access & PWRITE & (w_addr == 2'd0);
    assign w_div_wr    = w_access & PWRITE & (w_addr == 2'd2);
    assign w_ctrl_wr   = w_access & PWRITE & (w_addr == 2'd3);
    assign w_clear     = w_ctrl_wr & PWDATA[1];
    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_level     = r_wptr - r_rptr;
    assign w_level_rpt = 4'(w_level);
    assign w_push      = w_data_wr & ~w_full;
    assign w_fifo_rd   = r_mem[r_rptr[AW-1:0]];
    assign w_busy      = (r_state != S_IDLE);
    assign w_baud_tc   = (r_baud_cnt == 16'd0);
    // Only PADDR[3:2] and the low half of PWDATA carry meaning.
    assign w_unused    = ^{PADDR[APB_ADDR_WIDTH-1:4], PADDR[1:0], PWDATA[31:16]};

    // A DATA write into a full FIFO stalls until the serializer frees a slot.
    assign PREADY       = ~(w_data_wr & w_full);
    assign PSLVERR      = w_access & PWRITE & (w_addr == 2'd1);
    assign uart_tx      = r_tx;
    assign tx_empty_irq = w_empty & ~w_busy;

    // Read mux straight from register state.
    always_comb begin
        PRDATA = '0;
        case (w_addr)
            2'd1:    PRDATA[7:0]  = {w_level_rpt, 1'b0, w_busy, w_empty, w_full};
            2'd2:    PRDATA[15:0] = r_div;
            2'd3:    PRDATA[0]    = r_enable;
            default: PRDATA       = '0;
        endcase
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= PWDATA[7:0];
    end

    // FIFO pointers; clear and reset flush the queue.
    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div    <= 16'd0;
            r_enable <= 1'b0;
        end else begin
            if (w_div_wr)  r_div    <= PWDATA[15:0];
            if (w_ctrl_wr) r_enable <= PWDATA[0];
        end
    end

    // Serializer next-state, line value and counter updates.
    always_comb begin
        w_state_nxt   = r_state;
        w_tx_nxt      = r_tx;
        w_baud_nxt    = r_baud_cnt;
        w_div_lat_nxt = r_div_lat;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_parity_nxt  = r_parity;
        w_start       = 1'b0;
        w_pop         = 1'b0;

        if (r_state != S_IDLE)
            w_baud_nxt = w_baud_tc ? r_div_lat : r_baud_cnt - 16'd1;

        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (r_enable && !w_empty) w_start = 1'b1;
            end
            S_START: begin
                if (w_baud_tc) begin
                    w_state_nxt   = S_DATA;
                    w_tx_nxt      = r_shift[0];
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_cnt_nxt = 3'd0;
                end
            end
            S_DATA: begin
                if (w_baud_tc) begin
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = r_parity;
`else
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_tx_nxt      = r_shift[0];
                        w_shift_nxt   = r_shift >> 1;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_tc) begin
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_tc) begin
                    if (r_enable && !w_empty) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                        w_baud_nxt  = 16'd0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
                w_baud_nxt  = 16'd0;
            end
        endcase

        // Frame start: pop the byte and latch the divisor for the whole frame.
        if (w_start) begin
            w_pop         = 1'b1;
            w_state_nxt   = S_START;
            w_tx_nxt      = 1'b0;
            w_shift_nxt   = w_fifo_rd;
            w_parity_nxt  = ^w_fifo_rd;
            w_baud_nxt    = r_div;
            w_div_lat_nxt = r_div;
            w_bit_cnt_nxt = 3'd0;
        end

        if (w_clear) begin
            w_pop         = 1'b0;
            w_state_nxt   = S_IDLE;
            w_tx_nxt      = 1'b1;
            w_baud_nxt    = 16'd0;
            w_bit_cnt_nxt = 3'd0;
        end
    end

    // Serializer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_baud_cnt <= 16'd0;
            r_div_lat  <= 16'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_parity   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx       <= w_tx_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_div_lat  <= w_div_lat_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
        end
    end
endmodule
